// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-flop sync, stability counter, level plus press/release strobes.
// Latency: clean change sampled at edge 1 shows on btn_level (with its strobe) at edge CNT_MAX+2.
// No backpressure: strobes are one-cycle, fire-and-forget; the consumer must take them when high.
// Optional long-press strobe compiled in with `define DEBOUNCE_LONG_PRESS_EN.
module debounce_multi #(
  parameter int N          = 4,
  parameter int CNT_MAX    = 1000000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int LONG_CNT   = 100000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse
);

  // Stability counter width; the counter never needs to hold CNT_MAX itself.
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  // Released level of a single channel (the idle value of the raw pin).
  localparam logic REL = ACTIVE_LOW;

`ifdef DEBOUNCE_LONG_PRESS_EN
  // Hold counter must be able to reach LONG_CNT exactly and then sit there.
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
`endif

  genvar g;
  for (g = 0; g < N; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_release;
    logic          w_diff;
    logic          w_done;

    // Synchronised input disagrees with the debounced level.
    assign w_diff = r_sync2 ^ r_level;
    // This edge completes CNT_MAX consecutive cycles of disagreement.
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    // Synchroniser, stability counter, debounced level and edge strobes.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync1   <= REL;
        r_sync2   <= REL;
        r_level   <= REL;
        r_cnt     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_sync1   <= btn_in[g];
        r_sync2   <= r_sync1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (!w_diff) begin
          // Any agreement with the current level restarts the stability window.
          r_cnt <= '0;
        end else if (!w_done) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          // Level flips and its strobe is registered on the same edge.
          r_cnt     <= '0;
          r_level   <= r_sync2;
          r_press   <= (r_sync2 != REL);
          r_release <= (r_sync2 == REL);
        end
      end
    end

    assign btn_level[g]     = r_level;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;

`ifdef DEBOUNCE_LONG_PRESS_EN
    logic [HW-1:0] r_hold;
    logic          r_long;
    logic          w_pressed;

    assign w_pressed = (r_level != REL);

    // Hold counter: counts debounced-pressed cycles, saturates, single strobe on arrival.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_hold <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= 1'b0;
        if (!w_pressed) begin
          r_hold <= '0;
        end else if (r_hold != HOLD_MAX) begin
          r_hold <= r_hold + 1'b1;
          // Saturation afterwards guarantees no repeat while still held.
          r_long <= (r_hold == HOLD_MAX - 1'b1);
        end
      end
    end

    assign long_pulse[g] = r_long;
`endif
  end

`ifndef DEBOUNCE_LONG_PRESS_EN
  // Feature compiled out: no hold state, strobe tied low (both arms are zero).
  assign long_pulse = (LONG_CNT > 0) ? {N{1'b0}} : {N{1'b0}};
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi (N=4, CNT_MAX=4, ACTIVE_LOW=1, LONG_CNT=10).
// Expected strobe events are queued by the stimulus; a monitor pops them as strobes appear.
// Long-press expectations follow `DEBOUNCE_LONG_PRESS_EN.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] long_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int       c;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] lv;
  } exp_t;

  exp_t exp_q[$];

  debounce_multi #(
    .N(4), .CNT_MAX(4), .ACTIVE_LOW(1'b1), .LONG_CNT(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with any strobe high must match the next queued event.
  always @(negedge clk) begin
    if (mon_en && ((press_pulse | release_pulse | long_pulse) !== 4'b0000)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d press=%b rel=%b long=%b lvl=%b",
                 cyc, press_pulse, release_pulse, long_pulse, btn_level);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.c != cyc || press_pulse !== e.p || release_pulse !== e.r ||
            long_pulse !== e.l || btn_level !== e.lv) begin
          bad++;
          $display("FAIL strobe_event got cyc=%0d p=%b r=%b l=%b lvl=%b want cyc=%0d p=%b r=%b l=%b lvl=%b",
                   cyc, press_pulse, release_pulse, long_pulse, btn_level,
                   e.c, e.p, e.r, e.l, e.lv);
        end
      end
    end
  end

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] lv);
    exp_t e;
    e.c = c; e.p = p; e.r = r; e.l = l; e.lv = lv;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_for(input logic [3:0] v, input int n);
    btn_in = v;
    idle(n);
  endtask

  task automatic chk_level(input string nm, input logic [3:0] want);
    total++;
    if (btn_level !== want) begin
      bad++;
      $display("FAIL %s: btn_level=%b want=%b (cyc=%0d)", nm, btn_level, want, cyc);
    end
  endtask

  initial begin
    int t;
    rst_n  = 1'b0;
    btn_in = 4'b1111;

    // Reset for three edges, then idle for 20 cycles with all buttons released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk_level("reset_idle", 4'b1111);
      idle(1);
    end

    // Clean press on ch0, held 30 cycles (long press), then release.
    t = cyc;
    push(t + 6, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
`ifdef DEBOUNCE_LONG_PRESS_EN
    push(t + 16, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
`endif
    push(t + 36, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
    btn_in = 4'b1110;
    idle(5);
    chk_level("press0_before", 4'b1111);
    idle(1);
    chk_level("press0_after", 4'b1110);
    idle(24);
    btn_in = 4'b1111;
    idle(5);
    chk_level("release0_before", 4'b1110);
    idle(1);
    chk_level("release0_after", 4'b1111);
    idle(4);

    // Bounce on ch1: 0x3, 1x1, 0x3, 1x2, then steady 0; level held pressed only 8 cycles.
    t = cyc;
    push(t + 15, 4'b0010, 4'b0000, 4'b0000, 4'b1101);
    push(t + 23, 4'b0000, 4'b0010, 4'b0000, 4'b1111);
    drive_for(4'b1101, 3);
    drive_for(4'b1111, 1);
    drive_for(4'b1101, 3);
    drive_for(4'b1111, 2);
    btn_in = 4'b1101;
    idle(5);
    chk_level("bounce1_before", 4'b1111);
    idle(1);
    chk_level("bounce1_after", 4'b1101);
    idle(2);
    btn_in = 4'b1111;
    idle(6);
    chk_level("release1", 4'b1111);
    idle(4);

    // Channels 2 and 3 pressed together, released together.
    t = cyc;
    push(t + 6, 4'b1100, 4'b0000, 4'b0000, 4'b0011);
    push(t + 14, 4'b0000, 4'b1100, 4'b0000, 4'b1111);
    btn_in = 4'b0011;
    idle(6);
    chk_level("simul_press", 4'b0011);
    idle(2);
    btn_in = 4'b1111;
    idle(6);
    chk_level("simul_release", 4'b1111);
    idle(4);

    // Reset in the middle of a ch2 count; the count restarts from scratch afterwards.
    btn_in = 4'b1011;
    idle(3);
    rst_n = 1'b0;
    idle(2);
    chk_level("midcount_reset", 4'b1111);
    rst_n = 1'b1;
    t = cyc;
    push(t + 6, 4'b0100, 4'b0000, 4'b0000, 4'b1011);
    push(t + 14, 4'b0000, 4'b0100, 4'b0000, 4'b1111);
    idle(5);
    chk_level("restart_before", 4'b1111);
    idle(1);
    chk_level("restart_after", 4'b1011);
    idle(2);
    btn_in = 4'b1111;
    idle(6);
    chk_level("restart_release", 4'b1111);
    idle(10);

    // Every queued event must have been seen.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes: pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
